// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with shadow/commit load,
// leading-zero suppression, per-digit blanking and anti-ghost dead time.
module seg7_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD           = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  lz_en_i,
  output logic                  pending_o,
  output logic                  frame_o,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     sel_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   sh_data;
  logic [DIGITS-1:0]     sh_dp;
  logic [DIGITS-1:0]     sh_blank;
  logic [4*DIGITS-1:0]   ds_data;
  logic [DIGITS-1:0]     ds_dp;
  logic [DIGITS-1:0]     ds_blank;
  logic                  pending;
  logic                  cnt_wrap;
  logic                  frame;
  logic                  live;
  logic [DIGITS-1:0]     zero_up;
  logic                  zero_run;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  dark;
  logic [7:0]            seg_raw;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign frame     = cnt_wrap && (idx == IDX_LAST);
  assign frame_o   = frame;
  assign pending_o = pending;

  generate
    if (DEAD == 0) begin : g_nodead
      assign live = 1'b1;
    end else begin : g_dead
      assign live = (cnt >= CW'(DEAD));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Commit reads the old shadow even when a load lands on the frame cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      ds_data  <= '0;
      ds_dp    <= '0;
      ds_blank <= '0;
      pending  <= 1'b0;
    end else begin
      if (frame && pending) begin
        ds_data  <= sh_data;
        ds_dp    <= sh_dp;
        ds_blank <= sh_blank;
      end
      if (load_i && cs) begin
        sh_data  <= data_i;
        sh_dp    <= dp_i;
        sh_blank <= blank_i;
        pending  <= 1'b1;
      end else if (frame) begin
        pending  <= 1'b0;
      end
    end
  end

  // zero_up[i]: nibbles i..DIGITS-1 of the display are all zero.
  always_comb begin
    zero_up  = '0;
    zero_run = 1'b1;
    nib      = 4'h0;
    dp_bit   = 1'b0;
    dark     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (ds_data[4*i +: 4] == 4'h0);
      zero_up[i] = zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = ds_data[4*i +: 4];
        dp_bit = ds_dp[i];
        dark   = ds_blank[i] || (lz_en_i && zero_up[i] && (i != 0));
      end
    end
    seg_raw = dark ? 8'h00 : {dp_bit, hex7(nib)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_o <= SEL_OFF;
      seg_o <= SEG_OFF;
    end else if (live) begin
      sel_o <= SEL_OFF ^ (DIGITS'(1) << idx);
      seg_o <= SEG_OFF ^ seg_raw;
    end else begin
      sel_o <= SEL_OFF;
      seg_o <= SEG_OFF;
    end
  end

endmodule
